fir_sat_mac_pipe: RTL and testbench
===================================

// Module: fir_sat_mac_pipe
// PURPOSE
//  Pipelined, parametrised signed saturating multiply-accumulate for the FIR datapath.
//  - Multiplies coefficient/sample pairs, scales by FRAC, saturates to WIDTH and
//    accumulates with saturation over a tap group terminated by in_last.
//  - Generalises the combinational 16-bit saturating multiply: width, fixed-point
//    scaling, accumulation, valid/ready flow control and overflow reporting.
// PARAMETERS
//  WIDTH  16  operand, product-after-scaling and accumulator width (signed, >=4)
//  FRAC   0   fractional bits; full product arithmetically shifted right by FRAC
//             (0 = integer, 15 = Q15 when WIDTH=16); 0 <= FRAC < WIDTH
// PORTS
//  system1000      in   1      clock, rising edge
//  system1000_rst  in   1      reset, asynchronous, active-high
//  in_valid        in   1      operand pair valid
//  in_ready        out  1      block accepts operands this cycle
//  in_a            in   WIDTH  signed operand (sample)
//  in_b            in   WIDTH  signed operand (coefficient)
//  in_last         in   1      pair is the final tap of the current group
//  out_valid       out  1      accumulated result valid
//  out_ready       in   1      downstream accepts result
//  out_data        out  WIDTH  signed saturated accumulated result
//  out_sat         out  1      any saturation occurred within this group
// BEHAVIOUR
//  - Reset (async): all stage valids, accumulator, sticky sat, out_valid, out_data
//    and out_sat go to 0; in_ready reads 1 one cycle after reset release.
//  - adv = !out_valid | out_ready; in_ready = adv. All stages advance only on adv.
//  - S1: on in_valid & in_ready, register a, b, last; v1 = 1, else v1 = 0 (on adv).
//  - S2: p = a*b, full 2*WIDTH signed; v2/last2 follow S1.
//  - S3: s = p >>> FRAC; m = s clamped to [-2^(W-1), 2^(W-1)-1];
//    acc_n = clamp(acc + m) (add in W+1 bits). Sticky sat |= clamp hit in either step.
//  - On v3 & last3: out_data <= acc_n, out_sat <= sticky | this-cycle clamp,
//    out_valid <= 1, acc <= 0, sticky <= 0. Else on v3: acc <= acc_n.
//  - Latency: last pair accepted at cycle t -> out_valid at t+3 (no stall).
//  - out_valid clears on out_ready unless a new result loads the same cycle
//    (then out_data/out_sat replaced, out_valid stays 1, no bubble).
//  - Stall: out_valid & !out_ready freezes S1..S3, acc and output; in_ready = 0.
//  - Bubbles (in_valid = 0) never disturb acc; a group may span any number of cycles.
//  - Group of one pair (in_last on first) outputs clamp(m) directly.
//  - Extremes: (-2^(W-1))*(-2^(W-1)) with FRAC=0 saturates to max, sat = 1.
//  - Reset mid-group discards partial acc; next accepted pair starts a new group.
// CONFIGURATION
//  FIR_SAT_MAC_ROUND_EN
//   defined:   S3 adds 2^(FRAC-1) to p before the shift (round half up); with
//              FRAC = 0 no effect. Overflow from rounding is covered by the clamp.
//   undefined: truncation toward -inf (plain arithmetic shift). Latency identical.
// TESTING  (WIDTH=16 unless noted)
//  1 FRAC=0, single pair a=300,b=100,last -> 3 cycles later out_data=30000, sat=0.
//  2 FRAC=0, a=300,b=200,last -> 32767, sat=1; a=-300,b=200,last -> -32768, sat=1.
//  3 FRAC=0, group (100,200),(100,200),(10,5,last) -> 40050 clamps: 32767, sat=1;
//    following group (2,3,last) -> 6, sat=0 (sticky cleared).
//  4 FRAC=15, a=0x4000,b=0x4000,last -> 0x2000; a=1,b=0x4000 -> 0 without
//    FIR_SAT_MAC_ROUND_EN, 1 with it; a=b=0x8000 -> 0x7FFF, sat=1.
//  5 Backpressure: hold out_ready=0 with result pending, stream 4 pairs ->
//    in_ready=0, outputs frozen; release -> results in order, none lost/duplicated.
//  6 Assert reset mid-group after 2 pairs -> outputs 0 immediately; new group
//    (7,7,last) -> 49, sat=0.

Source files
------------

// File: rtl/fir_sat_mac_pipe.sv
// fir_sat_mac_pipe
//   Pipelined signed saturating multiply-accumulate for the FIR datapath.
//   Each accepted (in_a, in_b) pair is multiplied to a full 2*WIDTH product.
//   The product is arithmetically shifted right by FRAC and clamped to WIDTH
//   bits. It is then added, with saturation, into a running accumulator.
//   The pair flagged with in_last closes the tap group: the accumulated value
//   is presented on out_data, and out_sat reports whether any clamp fired
//   anywhere in that group.
//
// Optional build macro:
//   FIR_SAT_MAC_ROUND_EN  add 2^(FRAC-1) to the product before the shift
//                         (round half up); without it the shift truncates
//                         toward -inf. Latency is the same either way.
//
// Parameters:
//   WIDTH  operand / scaled product / accumulator width (signed, >= 4)
//   FRAC   fractional bits removed from the product, 0 <= FRAC < WIDTH
//
// Ports:
//   system1000      in   1      clock, rising edge
//   system1000_rst  in   1      asynchronous reset, active-high
//   in_valid        in   1      operand pair valid
//   in_ready        out  1      operand pair accepted this cycle when valid
//   in_a            in   WIDTH  signed sample
//   in_b            in   WIDTH  signed coefficient
//   in_last         in   1      pair is the final tap of the group
//   out_valid       out  1      accumulated result valid
//   out_ready       in   1      downstream accepts the result
//   out_data        out  WIDTH  signed saturated group result
//   out_sat         out  1      a saturation occurred within the group
//
// Latency: a last pair accepted in cycle t gives out_valid in cycle t+3.
module fir_sat_mac_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 0
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    localparam int PW = 2 * WIDTH + 1;

    localparam logic signed [WIDTH-1:0] WMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] WMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0]    PMAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]    PMIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

`ifdef FIR_SAT_MAC_ROUND_EN
    // Half an LSB of the scaled result; evaluates to zero when FRAC = 0.
    localparam logic signed [PW-1:0] RND = (PW'(1) << FRAC) >> 1;
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    // Scaled product clamp; the extra bit over 2*WIDTH absorbs rounding carry.
    function automatic logic prod_ovf(input logic signed [PW-1:0] x);
        return (x > PMAX) || (x < PMIN);
    endfunction

    function automatic logic signed [WIDTH-1:0] prod_sat(input logic signed [PW-1:0] x);
        if (x > PMAX) begin
            return WMAX;
        end else if (x < PMIN) begin
            return WMIN;
        end else begin
            return x[WIDTH-1:0];
        end
    endfunction

    // Accumulator add in WIDTH+1 bits; overflow when the top two bits differ.
    function automatic logic [WIDTH:0] acc_sum(input logic signed [WIDTH-1:0] x,
                                               input logic signed [WIDTH-1:0] y);
        return {x[WIDTH-1], x} + {y[WIDTH-1], y};
    endfunction

    function automatic logic acc_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = acc_sum(x, y);
        return s[WIDTH] ^ s[WIDTH-1];
    endfunction

    function automatic logic signed [WIDTH-1:0] acc_sat(input logic signed [WIDTH-1:0] x,
                                                        input logic signed [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = acc_sum(x, y);
        if (s[WIDTH] ^ s[WIDTH-1]) begin
            return s[WIDTH] ? WMIN : WMAX;
        end else begin
            return s[WIDTH-1:0];
        end
    endfunction

    // Whole pipeline moves together whenever the output slot can take a result.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic                      vld_p0, last_p0;
    logic signed [WIDTH-1:0]   a_p0, b_p0;
    logic                      vld_p1, last_p1;
    logic signed [2*WIDTH-1:0] prod_p1;
    logic signed [WIDTH-1:0]   acc;
    logic                      sticky;

    // ---- Stage 1: operand capture / Stage 2: full-width product ----
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge system1000) begin
        if (adv) begin
            a_p0    <= in_a;
            b_p0    <= in_b;
            last_p0 <= in_last;
            prod_p1 <= (2*WIDTH)'(a_p0) * (2*WIDTH)'(b_p0);
            last_p1 <= last_p0;
        end
    end

    // ---- Stage 3: scale, clamp, saturating accumulate ----
    logic signed [PW-1:0]    prod_x, prod_r, prod_s;
    logic signed [WIDTH-1:0] m, acc_n;
    logic                    sat_now;

    always_comb begin
        prod_x  = {prod_p1[2*WIDTH-1], prod_p1};
        prod_r  = prod_x + RND;
        prod_s  = prod_r >>> FRAC;
        m       = prod_sat(prod_s);
        acc_n   = acc_sat(acc, m);
        sat_now = prod_ovf(prod_s) || acc_ovf(acc, m);
    end

    // ---- Output register: group result with skid-free replace on handshake ----
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            acc       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            if (vld_p1 && last_p1) begin
                out_data  <= acc_n;
                out_sat   <= sticky || sat_now;
                out_valid <= 1'b1;
                acc       <= '0;
                sticky    <= 1'b0;
            end else begin
                if (vld_p1) begin
                    acc    <= acc_n;
                    sticky <= sticky || sat_now;
                end
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_sat_mac_pipe.sv
module tb_fir_sat_mac_pipe;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                in_valid, in_last, out_ready;
    logic signed [W-1:0] in_a, in_b;
    logic                in_ready0, out_valid0, out_sat0;
    logic                in_ready1, out_valid1, out_sat1;
    logic signed [W-1:0] out_data0, out_data1;

    // Integer-scaled instance and Q15 instance fed the same operand stream.
    fir_sat_mac_pipe #(.WIDTH(W), .FRAC(0)) dut0 (
        .system1000(clk), .system1000_rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_sat(out_sat0)
    );

    fir_sat_mac_pipe #(.WIDTH(W), .FRAC(15)) dut1 (
        .system1000(clk), .system1000_rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_sat(out_sat1)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int d;
        bit s;
    } res_t;

    res_t   q0[$];
    res_t   q1[$];
    longint acc_m0, acc_m1;
    bit     st_m0, st_m1;
    bit     sends_done;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one accepted pair for a given FRAC.
    task automatic model_pair(input int frac, input int a, input int b, input bit last,
                              inout longint acc, inout bit st,
                              output bit push, output res_t r);
        longint p, s;
        bit     hit;
        p = longint'(a) * longint'(b);
`ifdef FIR_SAT_MAC_ROUND_EN
        if (frac > 0) p = p + (longint'(1) << (frac - 1));
`endif
        s   = p >>> frac;
        hit = 1'b0;
        if (s > 32767) begin s = 32767; hit = 1'b1; end
        else if (s < -32768) begin s = -32768; hit = 1'b1; end
        acc = acc + s;
        if (acc > 32767) begin acc = 32767; hit = 1'b1; end
        else if (acc < -32768) begin acc = -32768; hit = 1'b1; end
        push = last;
        r.d  = int'(acc);
        r.s  = st | hit;
        if (last) begin
            acc = 0;
            st  = 1'b0;
        end else begin
            st = st | hit;
        end
    endtask

    // Present a pair and hold it until accepted; the model sees it on acceptance.
    task automatic send(input int a, input int b, input bit last);
        bit   ok, push;
        res_t r;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = W'(a);
        in_b     = W'(b);
        in_last  = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready0) begin
                model_pair(0, a, b, last, acc_m0, st_m0, push, r);
                if (push) q0.push_back(r);
                model_pair(15, a, b, last, acc_m1, st_m1, push, r);
                if (push) q1.push_back(r);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("accept", 32'(ok), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output handshake pops the oldest expected result.
    always @(negedge clk) begin
        res_t r;
        if (!rst && out_ready) begin
            if (out_valid0) begin
                check("q0_pending", 32'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    r = q0.pop_front();
                    check("data_frac0", out_data0, r.d);
                    check("sat_frac0", 32'(out_sat0), 32'(r.s));
                end
            end
            if (out_valid1) begin
                check("q1_pending", 32'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    r = q1.pop_front();
                    check("data_frac15", out_data1, r.d);
                    check("sat_frac15", 32'(out_sat1), 32'(r.s));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        acc_m0     = 0;
        acc_m1     = 0;
        st_m0      = 1'b0;
        st_m1      = 1'b0;
        sends_done = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid0), 0);
        check("rst_out_data", out_data0, 0);
        check("rst_out_sat", 32'(out_sat0), 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready0), 1);
        @(posedge clk);
        #1;

        // Single pair, latency of three cycles: 300*100 = 30000.
        send(300, 100, 1);
        @(negedge clk);
        check("lat_c1", 32'(out_valid0), 0);
        @(negedge clk);
        check("lat_c2", 32'(out_valid0), 0);
        @(negedge clk);
        check("lat_c3", 32'(out_valid0), 1);
        idle(3);

        // Product saturation both ways.
        send(300, 200, 1);
        send(-300, 200, 1);
        idle(6);

        // Accumulator saturation then a clean group (sticky must clear).
        send(100, 200, 0);
        send(100, 200, 0);
        send(10, 5, 1);
        send(2, 3, 1);
        idle(6);

        // Bubbles inside a group leave the accumulator alone: 1 + 4 = 5.
        send(1, 1, 0);
        idle(3);
        send(2, 2, 1);
        idle(6);

        // Q15 cases, including the most-negative squared extreme.
        send(16384, 16384, 1);
        send(1, 16384, 1);
        send(-32768, -32768, 1);
        idle(6);

        // Backpressure: first result stalls, pipeline freezes behind it.
        out_ready = 1'b0;
        send(1, 2, 1);
        send(3, 4, 1);
        send(5, 6, 1);
        fork
            begin
                send(7, 1, 1);
                send(8, 1, 1);
                send(9, 1, 0);
                send(10, 1, 1);
                sends_done = 1'b1;
            end
        join_none
        repeat (4) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready0), 0);
            check("stall_out_valid", 32'(out_valid0), 1);
            check("stall_out_data", out_data0, 2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !sends_done; i++) @(posedge clk);
        check("stream_done", 32'(sends_done), 1);
        idle(8);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        // Reset in the middle of a group discards the partial sum.
        send(5, 5, 0);
        send(6, 6, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid0), 0);
        check("midrst_out_data", out_data0, 0);
        check("midrst_out_data_q15", out_data1, 0);
        check("midrst_out_sat", 32'(out_sat0), 0);
        acc_m0 = 0;
        acc_m1 = 0;
        st_m0  = 1'b0;
        st_m1  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(7, 7, 1);
        idle(6);
        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
